// File: rtl/mandelbrot_pkg.sv
// Shared defaults, count-field position and scan FSM encoding for the mandelbrot frame buffer.
package mandelbrot_pkg;
  localparam int RESX_DEF  = 32;
  localparam int RESY_DEF  = 32;
  localparam int PIX_W_DEF = 81;
  localparam int CNT_W_DEF = 16;
  localparam int CNT_LSB   = 0;
  localparam int IMAX_DEF  = 16;
  localparam int CW_DEF    = 11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;
endpackage

// File: rtl/mandelbrot_fb_if.sv
// Scan-out stream: iteration count plus start-of-frame / end-of-line markers over valid/ready.
interface mandelbrot_fb_if #(parameter int CNT_W = 16);
  logic             sc_valid;
  logic             sc_ready;
  logic [CNT_W-1:0] sc_data;
  logic             sc_sof;
  logic             sc_eol;

  modport master (output sc_valid, sc_data, sc_sof, sc_eol, input sc_ready);
  modport slave  (input sc_valid, sc_data, sc_sof, sc_eol, output sc_ready);
endinterface

// File: rtl/fb_scan_ctrl.sv
// Raster scan-out of the frame buffer: one registered pixel per accepted beat, payload held while stalled.
module fb_scan_ctrl import mandelbrot_pkg::*; #(
  parameter int RESX  = RESX_DEF,
  parameter int RESY  = RESY_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int IMAX  = IMAX_DEF,
  localparam int XW   = $clog2(RESX),
  localparam int YW   = $clog2(RESY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_done_i,
  input  logic             scan_start_i,
  output logic [XW-1:0]    rd_x_o,
  output logic [YW-1:0]    rd_y_o,
  input  logic [CNT_W-1:0] rd_cnt_i,
  input  logic             sc_ready_i,
  output logic             sc_valid_o,
  output logic [CNT_W-1:0] sc_data_o,
  output logic             sc_sof_o,
  output logic             sc_eol_o,
  output logic             scan_busy_o,
  output logic             scan_done_o
);
  scan_state_e      state_q, state_d;
  logic [XW-1:0]    sx_q, sx_d, rx;
  logic [YW-1:0]    sy_q, sy_d, ry;
  logic             vld_q, vld_d, sof_q, sof_d, eol_q, eol_d, done_q, done_d, load;
  logic [CNT_W-1:0] dat_q, dat_d;
  logic             last_pix;

  assign last_pix = (sx_q == XW'(RESX - 1)) && (sy_q == YW'(RESY - 1));

  // rx/ry is the pixel loaded into the output register at the coming edge.
  always_comb begin
    state_d = state_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    vld_d   = vld_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    done_d  = 1'b0;
    load    = 1'b0;
    rx      = '0;
    ry      = '0;
    case (state_q)
      ST_IDLE: begin
        if (scan_start_i && frame_done_i) begin
          state_d = ST_SCAN;
          sx_d    = '0;
          sy_d    = '0;
        end
      end
      ST_SCAN: begin
        if (!vld_q) begin
          load = 1'b1;
        end else if (sc_ready_i) begin
          if (last_pix) begin
            vld_d   = 1'b0;
            sof_d   = 1'b0;
            eol_d   = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            load = 1'b1;
            if (sx_q == XW'(RESX - 1)) begin
              rx = '0;
              ry = sy_q + 1'b1;
            end else begin
              rx = sx_q + 1'b1;
              ry = sy_q;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      sx_d  = rx;
      sy_d  = ry;
      vld_d = 1'b1;
      sof_d = (rx == '0) && (ry == '0);
      eol_d = (rx == XW'(RESX - 1));
    end
  end

  always_comb begin
    dat_d = dat_q;
    if (load) dat_d = (rd_cnt_i > CNT_W'(IMAX)) ? CNT_W'(IMAX) : rd_cnt_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sx_q    <= '0;
      sy_q    <= '0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      done_q  <= done_d;
    end
  end

  assign rd_x_o      = rx;
  assign rd_y_o      = ry;
  assign sc_valid_o  = vld_q;
  assign sc_data_o   = dat_q;
  assign sc_sof_o    = sof_q;
  assign sc_eol_o    = eol_q;
  assign scan_busy_o = (state_q == ST_SCAN);
  assign scan_done_o = done_q;
endmodule

// File: rtl/mandelbrot_fb.sv
// Frame buffer: raster capture of pout, combinational recirculation read on pin, valid/ready scan-out.
// Optional MANDELBROT_FB_WRTRACK_EN adds a written-bit per pixel; unwritten pixels scan out as IMAX.
module mandelbrot_fb import mandelbrot_pkg::*; #(
  parameter int RESX  = RESX_DEF,
  parameter int RESY  = RESY_DEF,
  parameter int PIX_W = PIX_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int IMAX  = IMAX_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             output_ready,
  input  logic [PIX_W-1:0] pout,
  input  logic [CW-1:0]    xin,
  input  logic [CW-1:0]    yin,
  output logic [PIX_W-1:0] pin,
  output logic             frame_done,
  input  logic             scan_start,
  output logic             scan_busy,
  output logic             scan_done,
  mandelbrot_fb_if.master  sc
);
  localparam int NPIX = RESX * RESY;
  localparam int AW   = $clog2(NPIX);
  localparam int XW   = $clog2(RESX);
  localparam int YW   = $clog2(RESY);

  logic [PIX_W-1:0] mem [NPIX];
  logic [XW-1:0]    wx_q, wx_d, sx;
  logic [YW-1:0]    wy_q, wy_d, sy;
  logic             fd_q, fd_d;
  logic [AW-1:0]    waddr, raddr, saddr;
  logic             in_range, rd_ok;
  logic [CNT_W-1:0] scan_cnt;

  assign waddr = AW'(wy_q) * AW'(RESX) + AW'(wx_q);
  assign raddr = AW'(yin) * AW'(RESX) + AW'(xin);
  assign saddr = AW'(sy) * AW'(RESX) + AW'(sx);

  always_comb begin
    wx_d = wx_q;
    wy_d = wy_q;
    fd_d = fd_q;
    if (output_ready) begin
      if (wx_q == XW'(RESX - 1)) begin
        wx_d = '0;
        if (wy_q == YW'(RESY - 1)) begin
          wy_d = '0;
          fd_d = 1'b1;
        end else begin
          wy_d = wy_q + 1'b1;
        end
      end else begin
        wx_d = wx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wx_q <= '0;
      wy_q <= '0;
      fd_q <= 1'b0;
    end else begin
      wx_q <= wx_d;
      wy_q <= wy_d;
      fd_q <= fd_d;
    end
  end

  // Storage is deliberately not reset; both read ports see the pre-edge word.
  always_ff @(posedge clk) begin
    if (output_ready) mem[waddr] <= pout;
  end

  assign in_range = (xin < CW'(RESX)) && (yin < CW'(RESY));

`ifdef MANDELBROT_FB_WRTRACK_EN
  logic [NPIX-1:0] wr_q;

  always_ff @(posedge clk) begin
    if (!rst_n)            wr_q        <= '0;
    else if (output_ready) wr_q[waddr] <= 1'b1;
  end

  assign rd_ok    = fd_q && in_range && wr_q[raddr];
  assign scan_cnt = wr_q[saddr] ? mem[saddr][CNT_LSB +: CNT_W] : CNT_W'(IMAX);
`else
  assign rd_ok    = fd_q && in_range;
  assign scan_cnt = mem[saddr][CNT_LSB +: CNT_W];
`endif

  assign pin        = rd_ok ? mem[raddr] : '0;
  assign frame_done = fd_q;

  fb_scan_ctrl #(
    .RESX  (RESX),
    .RESY  (RESY),
    .CNT_W (CNT_W),
    .IMAX  (IMAX)
  ) u_scan (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_done_i (fd_q),
    .scan_start_i (scan_start),
    .rd_x_o       (sx),
    .rd_y_o       (sy),
    .rd_cnt_i     (scan_cnt),
    .sc_ready_i   (sc.sc_ready),
    .sc_valid_o   (sc.sc_valid),
    .sc_data_o    (sc.sc_data),
    .sc_sof_o     (sc.sc_sof),
    .sc_eol_o     (sc.sc_eol),
    .scan_busy_o  (scan_busy),
    .scan_done_o  (scan_done)
  );
endmodule
